// File: rtl/udp_payload_packer.sv
// Pulls PAYLOAD_BYTES/2 samples from the payload generator through a small
// FIFO and serialises them big-endian onto an 8-bit valid/ready stream.
module udp_payload_packer #(
    parameter int PAYLOAD_BYTES = 64,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        rng_enable,
    input  logic [15:0] rng_sample,
    input  logic        rng_valid,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast
);

    localparam int SAMPLES = PAYLOAD_BYTES / 2;
    localparam int REQ_W   = $clog2(SAMPLES + 1);
    localparam int BYTE_W  = $clog2(PAYLOAD_BYTES);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [REQ_W-1:0]  REQ_MAX   = REQ_W'(SAMPLES);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(PAYLOAD_BYTES - 1);
    localparam logic [CNT_W:0]    OCC_MAX   = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [REQ_W-1:0]  r_req_cnt;
    logic [BYTE_W-1:0] r_byte_cnt;
    logic [CNT_W-1:0]  r_fifo_cnt;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [15:0]       r_mem [FIFO_DEPTH];
    logic              r_inflight;
    logic              r_phase;
    logic              r_tvalid;

    logic              w_start_ok;
    logic              w_run;
    logic              w_en;
    logic              w_hs;
    logic              w_wr;
    logic              w_pop;
    logic              w_last;
    logic [CNT_W:0]    w_occ;
    logic [CNT_W-1:0]  w_fifo_nxt;
    logic [15:0]       w_head;

    assign w_start_ok = (r_state == S_IDLE) & start;
    assign w_hs       = r_tvalid & m_tready;
    assign w_wr       = rng_valid & r_inflight;
    assign w_pop      = w_hs & r_phase;
    assign w_last     = r_tvalid & (r_byte_cnt == BYTE_LAST);
    assign w_head     = r_mem[r_rd_ptr];

    // Outstanding request counts against FIFO space so no sample is dropped
    assign w_occ = {1'b0, r_fifo_cnt} + (CNT_W + 1)'(r_inflight);
    assign w_en  = w_run & (r_req_cnt < REQ_MAX) & (w_occ < OCC_MAX);

    always_comb begin
        w_fifo_nxt = r_fifo_cnt;
        unique case ({w_wr, w_pop})
            2'b10:   w_fifo_nxt = r_fifo_cnt + 1'b1;
            2'b01:   w_fifo_nxt = r_fifo_cnt - 1'b1;
            default: w_fifo_nxt = r_fifo_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_hs && w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        w_run      = (r_state == S_RUN);
        rng_enable = w_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_cnt  <= '0;
            r_byte_cnt <= '0;
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_phase    <= 1'b0;
            r_tvalid   <= 1'b0;
        end else if (w_start_ok) begin
            r_req_cnt  <= '0;
            r_byte_cnt <= '0;
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_phase    <= 1'b0;
            r_tvalid   <= 1'b0;
        end else begin
            r_inflight <= w_en;
            if (w_en) begin
                r_req_cnt <= r_req_cnt + 1'b1;
            end
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_hs) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
                r_phase    <= ~r_phase;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_fifo_cnt <= w_fifo_nxt;
            // Registered valid tracks the occupancy the FIFO will have next
            r_tvalid   <= (w_fifo_nxt != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr && !w_start_ok) begin
            r_mem[r_wr_ptr] <= rng_sample;
        end
    end

    assign m_tvalid = r_tvalid;
    assign m_tlast  = w_last;
    assign m_tdata  = !r_tvalid ? 8'h00 :
                      r_phase   ? w_head[7:0] : w_head[15:8];

endmodule

// File: tb/tb_udp_payload_packer.sv
// Directed bench: rotating payload generator model, byte scoreboard,
// stall/backpressure, restart-ignore, mid-payload reset and stray-valid cases.
module tb_udp_payload_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        rng_enable;
    logic [15:0] rng_sample;
    logic        rng_valid;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;

    logic [15:0] g_state = 16'h0001;
    logic [15:0] g_sample = 16'h0000;
    logic        g_valid = 1'b0;
    logic        s_stray = 1'b0;

    int total = 0;
    int bad = 0;
    int en_cnt = 0;
    int pay_bytes = 0;
    int pay_last = 0;
    int done_cnt = 0;
    int bubbles = 0;
    bit seen_first = 0;
    bit prev_stall = 0;
    logic [7:0] prev_d = 8'h00;
    logic prev_l = 1'b0;
    logic [7:0] cap [64];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    udp_payload_packer #(
        .PAYLOAD_BYTES(64),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .rng_enable(rng_enable),
        .rng_sample(rng_sample),
        .rng_valid(rng_valid),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast(m_tlast)
    );

    assign rng_sample = s_stray ? 16'hDEAD : g_sample;
    assign rng_valid  = g_valid | s_stray;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Generator model: sample is the pre-rotate state, valid one cycle later
    always @(posedge clk) begin
        g_valid <= rng_enable;
        if (rng_enable) begin
            g_sample <= g_state;
            exp_q.push_back(g_state[15:8]);
            exp_q.push_back(g_state[7:0]);
            g_state <= {g_state[14:0], g_state[15]};
            en_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", int'(m_tvalid), 1);
                chk("hold_data", int'(m_tdata), int'(prev_d));
                chk("hold_last", int'(m_tlast), int'(prev_l));
            end
            if (m_tvalid && m_tready) begin
                chk("sb_avail", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("data", int'(m_tdata), int'(exp_q.pop_front()));
                end
                chk("last_pos", int'(m_tlast), int'(pay_bytes == 63));
                if (pay_bytes < 64) cap[pay_bytes] = m_tdata;
                pay_bytes++;
                if (m_tlast) pay_last++;
            end
            if (done) done_cnt++;
            if (seen_first && !m_tvalid && busy && !done) bubbles++;
            if (m_tvalid) seen_first = 1;
            prev_stall = m_tvalid && !m_tready;
            prev_d = m_tdata;
            prev_l = m_tlast;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        pay_bytes = 0;
        pay_last = 0;
        en_cnt = 0;
        bubbles = 0;
        seen_first = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            if (rnd) m_tready = 1'($urandom_range(0, 1));
            n++;
        end
        chk("done_seen", int'(done), 1);
    endtask

    task automatic end_checks();
        chk("bytes", pay_bytes, 64);
        chk("lasts", pay_last, 1);
        chk("en_cycles", en_cnt, 32);
        chk("busy_in_done", int'(busy), 1);
        tick();
        chk("done_pulse", int'(done), 0);
        chk("busy_off", int'(busy), 0);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outs();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_en", int'(rng_enable), 0);
        chk("rst_tvalid", int'(m_tvalid), 0);
        chk("rst_tlast", int'(m_tlast), 0);
        chk("rst_tdata", int'(m_tdata), 0);
    endtask

    initial begin
        logic [7:0] a8 [8];
        int d0;
        int n;
        a8 = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h08};

        #22;
        chk_reset_outs();
        tick();
        rst_n = 1'b1;
        tick();

        // Stray valid in IDLE must not land in the FIFO
        s_stray = 1'b1;
        tick();
        s_stray = 1'b0;
        tick();
        tick();
        chk("stray_tvalid", int'(m_tvalid), 0);
        chk("stray_busy", int'(busy), 0);

        // Payload A: full rate
        m_tready = 1'b1;
        chk("idle_busy", int'(busy), 0);
        pulse_start();
        chk("c1_busy", int'(busy), 1);
        chk("c1_en", int'(rng_enable), 1);
        tick();
        chk("c2_tvalid", int'(m_tvalid), 0);
        wait_done(0, 300);
        chk("bubbles", bubbles, 0);
        for (int i = 0; i < 8; i++) begin
            chk("first_bytes", int'(cap[i]), int'(a8[i]));
        end
        chk("no_stray", int'(cap[0] != 8'hDE), 1);
        end_checks();

        // Payload B: backpressure after first valid
        m_tready = 1'b0;
        pulse_start();
        n = 0;
        while (!m_tvalid && n < 20) begin
            tick();
            n++;
        end
        chk("b_first_valid", int'(m_tvalid), 1);
        repeat (40) tick();
        chk("b_en_stopped", int'(rng_enable), 0);
        chk("b_en_at_stall", en_cnt, 4);
        chk("b_no_bytes", pay_bytes, 0);
        m_tready = 1'b1;
        wait_done(0, 300);
        end_checks();

        // Random backpressure over many payloads
        for (int p = 0; p < 100; p++) begin
            m_tready = 1'($urandom_range(0, 1));
            pulse_start();
            wait_done(1, 2000);
            end_checks();
        end

        // Start pulses while running are ignored
        m_tready = 1'b1;
        d0 = done_cnt;
        pulse_start();
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_busy", int'(busy), 1);
        wait_done(0, 300);
        end_checks();
        repeat (3) tick();
        chk("rs_one_done", done_cnt - d0, 1);

        // Async reset after 10 bytes, then a fresh payload
        pulse_start();
        n = 0;
        while (pay_bytes < 10 && n < 100) begin
            tick();
            n++;
        end
        chk("mr_ten", pay_bytes, 10);
        rst_n = 1'b0;
        #1;
        chk_reset_outs();
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        wait_done(0, 300);
        end_checks();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
